// File: rtl/izhikevich_array.sv
// Time-multiplexed array of Izhikevich neurons sharing one saturating fixed-point
// update datapath; each start pulse advances every neuron once and reports spikes.
module izhikevich_array #(
  parameter int N           = 32,
  parameter int Q           = 16,
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_we,
  input  logic [IDX_W-1:0]       init_idx,
  input  logic signed [N-1:0]    v_init,
  input  logic signed [N-1:0]    w_init,
  input  logic                   i_we,
  input  logic [IDX_W-1:0]       i_idx,
  input  logic signed [N-1:0]    i_data,
  input  logic signed [N-1:0]    v_th,
  input  logic signed [N-1:0]    step,
  input  logic signed [N-1:0]    a,
  input  logic signed [N-1:0]    b,
  input  logic signed [N-1:0]    c,
  input  logic signed [N-1:0]    d,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_NEURONS-1:0] spike,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic signed [N-1:0]    rd_v,
  output logic signed [N-1:0]    rd_w
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic signed [N-1:0] S_MAX  = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] S_MIN  = {1'b1, {(N-1){1'b0}}};
  localparam longint              K004_L = ((longint'(4) << Q) + 50) / 100;
  localparam logic signed [N-1:0] K004   = N'(K004_L);
  localparam logic signed [N-1:0] K5     = N'(longint'(5) << Q);
  localparam logic signed [N-1:0] K140   = N'(longint'(140) << Q);
  localparam logic [IDX_W-1:0]    K_LAST = IDX_W'(NUM_NEURONS - 1);

  function automatic logic idx_ok(input logic [31:0] idx);
    return idx < 32'(NUM_NEURONS);
  endfunction

  function automatic logic signed [N-1:0] sat_add(input logic signed [N-1:0] x,
                                                  input logic signed [N-1:0] y);
    logic signed [N:0] s;
    s = {x[N-1], x} + {y[N-1], y};
    if (s[N] != s[N-1]) return s[N] ? S_MIN : S_MAX;
    return s[N-1:0];
  endfunction

  function automatic logic signed [N-1:0] sat_sub(input logic signed [N-1:0] x,
                                                  input logic signed [N-1:0] y);
    logic signed [N:0] s;
    s = {x[N-1], x} - {y[N-1], y};
    if (s[N] != s[N-1]) return s[N] ? S_MIN : S_MAX;
    return s[N-1:0];
  endfunction

  // Full-width signed product, floored by the arithmetic shift, then clamped.
  function automatic logic signed [N-1:0] fxmul(input logic signed [N-1:0] x,
                                                input logic signed [N-1:0] y);
    logic signed [2*N-1:0] p;
    p = {{N{x[N-1]}}, x} * {{N{y[N-1]}}, y};
    p = p >>> Q;
    if ((&p[2*N-1:N-1]) || !(|p[2*N-1:N-1])) return p[N-1:0];
    return p[2*N-1] ? S_MIN : S_MAX;
  endfunction

  state_e                   state_q;
  logic [IDX_W-1:0]         k_q;
  logic                     busy_q;
  logic                     done_q;
  logic [NUM_NEURONS-1:0]   spike_q;
  logic [NUM_NEURONS-1:0]   spike_acc_q;
  logic signed [N-1:0]      dv_q, dw_q;
  logic                     fire_q;

  logic signed [N-1:0]      v_q [NUM_NEURONS];
  logic signed [N-1:0]      w_q [NUM_NEURONS];
  logic signed [N-1:0]      i_q [NUM_NEURONS];

  logic signed [N-1:0]      v_cur, w_cur, i_cur, term;
  logic signed [N-1:0]      dv_d, dw_d;
  logic                     fire_d;

  // Shared datapath: evaluates the neuron selected by k_q from its current state.
  always_comb begin
    // NOTE: blocking assignments here -- term is rebuilt stage by stage in one evaluation.
    v_cur  = v_q[k_q];
    w_cur  = w_q[k_q];
    i_cur  = i_q[k_q];
    term   = sat_add(fxmul(fxmul(K004, v_cur), v_cur), fxmul(K5, v_cur));
    term   = sat_add(term, K140);
    term   = sat_sub(term, w_cur);
    term   = sat_add(term, i_cur);
    dv_d   = fxmul(step, term);
    dw_d   = fxmul(step, fxmul(a, sat_sub(fxmul(b, v_cur), w_cur)));
    fire_d = v_cur > v_th;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking for all state so every register samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      spike_q     <= '0;
      spike_acc_q <= '0;
      dv_q        <= '0;
      dw_q        <= '0;
      fire_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_CALC;
            k_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_CALC: begin
          dv_q    <= dv_d;
          dw_q    <= dw_d;
          fire_q  <= fire_d;
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          spike_acc_q[k_q] <= fire_q;
          if (k_q == K_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            k_q     <= k_q + 1'b1;
            state_q <= S_CALC;
          end
        end
        S_DONE: begin
          spike_q <= spike_acc_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Neuron state: host init only while idle, sweep writeback, current writes anytime.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the state arrays are plain flops and are cleared like any register,
      // so an aborted sweep leaves no stale neuron behind.
      for (int n = 0; n < NUM_NEURONS; n++) begin
        v_q[n] <= '0;
        w_q[n] <= '0;
        i_q[n] <= '0;
      end
    end else begin
      if (init_we && !busy_q && idx_ok(32'(init_idx))) begin
        v_q[init_idx] <= v_init;
        w_q[init_idx] <= w_init;
      end
      if (state_q == S_WRITE) begin
        if (fire_q) begin
          v_q[k_q] <= c;
          w_q[k_q] <= sat_add(w_q[k_q], d);
        end else begin
          v_q[k_q] <= sat_add(v_q[k_q], dv_q);
          w_q[k_q] <= sat_add(w_q[k_q], dw_q);
        end
      end
      if (i_we && idx_ok(32'(i_idx))) begin
        i_q[i_idx] <= i_data;
      end
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign spike = spike_q;
  assign rd_v  = idx_ok(32'(rd_idx)) ? v_q[rd_idx] : '0;
  assign rd_w  = idx_ok(32'(rd_idx)) ? w_q[rd_idx] : '0;

endmodule
